// File: rtl/axi_acp_responder.sv
// AXI4 burst slave over a 64-bit simple dual-port RAM.
// Loopback endpoint for ACP-master traffic kept inside the PL.
module axi_acp_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic [4:0]  S_AXI_AWUSER,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [4:0]  S_AXI_ARUSER,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [63:0] mem [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic                  w_inc_q, w_inc_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_we;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_err_q, r_err_d;
  logic                  r_inc_q, r_inc_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [63:0]           rdata_q;

  logic aw_bad;
  logic ar_bad;
  logic unused_ok;

  assign aw_bad = (S_AXI_AWSIZE != 3'd3) || S_AXI_AWBURST[1];
  assign ar_bad = (S_AXI_ARSIZE != 3'd3) || S_AXI_ARBURST[1];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWUSER,
                       S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARUSER,
                       S_AXI_AWADDR[31:ADDR_WIDTH+3],
                       S_AXI_AWADDR[2:0],
                       S_AXI_ARADDR[31:ADDR_WIDTH+3],
                       S_AXI_ARADDR[2:0]};

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_inc_d   = w_inc_q;
    w_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          w_idx_d   = S_AXI_AWADDR[ADDR_WIDTH+2:3];
          w_len_d   = S_AXI_AWLEN;
          w_cnt_d   = 8'd0;
          w_inc_d   = (S_AXI_AWBURST == 2'b01);
          w_err_d   = aw_bad;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          w_we = !w_err_q;
          // WLAST is only checked; the counter alone ends the burst
          if (S_AXI_WLAST != (w_cnt_q == w_len_q)) begin
            w_err_d = 1'b1;
          end
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            if (w_inc_q) begin
              w_idx_d = w_idx_q + IDX_ONE;
            end
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = (bvalid_d && w_err_d) ? 2'b10 : 2'b00;
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    r_inc_d   = r_inc_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          r_idx_d   = S_AXI_ARADDR[ADDR_WIDTH+2:3];
          r_len_d   = S_AXI_ARLEN;
          r_cnt_d   = 8'd0;
          r_inc_d   = (S_AXI_ARBURST == 2'b01);
          r_err_d   = ar_bad;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_q) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_FETCH;
            if (r_inc_q) begin
              r_idx_d = r_idx_q + IDX_ONE;
            end
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = rvalid_d && (r_cnt_d == r_len_d);
    rresp_d   = (rvalid_d && r_err_d) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      w_inc_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_err_q   <= 1'b0;
      r_inc_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      w_inc_q   <= w_inc_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
      r_inc_q   <= r_inc_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem[w_idx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port; non-blocking read gives read-first behaviour
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (r_state_q == R_FETCH) begin
      rdata_q <= r_err_q ? 64'd0 : mem[r_idx_q];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_acp_responder.sv
// Scoreboard bench for axi_acp_responder.
// Expected B/R results are queued at issue and popped at handshake.
module tb_axi_acp_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd3;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd3;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;

  axi_acp_responder #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWPROT(3'd0), .S_AXI_AWCACHE(4'd0),
    .S_AXI_AWUSER(5'd0),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARPROT(3'd0), .S_AXI_ARCACHE(4'd0),
    .S_AXI_ARUSER(5'd0),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic [1:0]  exp_b [$];
  rbeat_t      exp_r [$];
  logic [63:0] model [1024];
  logic [63:0] wdat  [256];
  logic [7:0]  wstb  [256];
  logic        wlst  [256];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          chk("stray_b", 64'd1, 64'd0);
        end else begin
          chk("bresp", {62'd0, bresp}, {62'd0, exp_b.pop_front()});
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          chk("stray_r", 64'd1, 64'd0);
        end else begin
          rbeat_t e;
          e = exp_r.pop_front();
          chk("rdata", rdata, e.data);
          chk("rresp", {62'd0, rresp}, {62'd0, e.resp});
          chk("rlast", {63'd0, rlast}, {63'd0, e.last});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr,
                           input logic [7:0]  len,
                           input logic [2:0]  size,
                           input logic [1:0]  burst);
    logic [9:0] idx;
    logic       err;
    logic       seen;
    int         n;
    idx = addr[12:3];
    err = (size != 3'd3) || burst[1];
    for (int k = 0; k <= int'(len); k++) begin
      if (!err) begin
        for (int b = 0; b < 8; b++) begin
          if (wstb[k][b]) model[idx][b*8 +: 8] = wdat[k][b*8 +: 8];
        end
      end
      if (wlst[k] != (k == int'(len))) err = 1'b1;
      if (burst == 2'b01) idx = idx + 10'd1;
    end
    exp_b.push_back(err ? 2'b10 : 2'b00);
    awaddr  = addr;
    awlen   = len;
    awsize  = size;
    awburst = burst;
    awvalid = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      seen = awready;
      step();
      n++;
    end
    if (!seen) chk("aw_timeout", 64'd0, 64'd1);
    awvalid = 1'b0;
    chk("wready_lat", {63'd0, wready}, 64'd1);
    chk("awready_busy", {63'd0, awready}, 64'd0);
    for (int k = 0; k <= int'(len); k++) begin
      wdata  = wdat[k];
      wstrb  = wstb[k];
      wlast  = wlst[k];
      wvalid = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 50) begin
        seen = wready;
        step();
        n++;
      end
      if (!seen) chk("w_timeout", 64'd0, 64'd1);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("bvalid_lat", {63'd0, bvalid}, 64'd1);
    step();
    chk("awready_back", {63'd0, awready}, 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr,
                          input logic [7:0]  len,
                          input logic [2:0]  size,
                          input logic [1:0]  burst,
                          input bit          stall);
    logic [9:0] idx;
    logic       bad;
    logic       seen;
    rbeat_t     e;
    int         n;
    idx = addr[12:3];
    bad = (size != 3'd3) || burst[1];
    for (int k = 0; k <= int'(len); k++) begin
      e.data = bad ? 64'd0 : model[idx];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (k == int'(len));
      exp_r.push_back(e);
      if (burst == 2'b01) idx = idx + 10'd1;
    end
    rready  = !stall;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      seen = arready;
      step();
      n++;
    end
    if (!seen) chk("ar_timeout", 64'd0, 64'd1);
    arvalid = 1'b0;
    chk("rvalid_early", {63'd0, rvalid}, 64'd0);
    step();
    chk("rvalid_lat", {63'd0, rvalid}, 64'd1);
    if (stall) begin
      repeat (5) begin
        step();
        chk("bp_rvalid", {63'd0, rvalid}, 64'd1);
        chk("bp_rdata", rdata, exp_r[0].data);
        chk("bp_rlast", {63'd0, rlast}, {63'd0, exp_r[0].last});
      end
      rready = 1'b1;
    end
    n = 0;
    while (exp_r.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_r.size() != 0) begin
      chk("r_timeout", 64'd0, 64'd1);
      exp_r.delete();
    end
  endtask

  task automatic set_beats(input int len, input logic [63:0] base);
    for (int k = 0; k <= len; k++) begin
      wdat[k] = base + 64'(k);
      wstb[k] = 8'hFF;
      wlst[k] = (k == len);
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ctl",
        {54'd0, awready, wready, bvalid, bresp,
         arready, rvalid, rresp, rlast}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    step();
    chk("awready_init", {63'd0, awready}, 64'd1);
    chk("arready_init", {63'd0, arready}, 64'd1);

    set_beats(0, 64'h0123456789ABCDEF);
    axi_write(32'h40, 8'd0, 3'd3, 2'b01);
    axi_read(32'h40, 8'd0, 3'd3, 2'b01, 1'b0);

    for (int k = 0; k < 16; k++) begin
      wdat[k] = 64'hFFFF_FFFF_FFFF_FFFF;
      wstb[k] = 8'hFF;
      wlst[k] = (k == 15);
    end
    axi_write(32'h1000, 8'd15, 3'd3, 2'b01);
    for (int k = 0; k < 16; k++) begin
      wdat[k] = 64'(k);
      wstb[k] = (k % 2 == 1) ? 8'h0F : 8'hFF;
      wlst[k] = (k == 15);
    end
    axi_write(32'h1000, 8'd15, 3'd3, 2'b01);
    axi_read(32'h1000, 8'd15, 3'd3, 2'b01, 1'b0);

    set_beats(3, 64'hA0);
    axi_write(32'h8, 8'd3, 3'd3, 2'b00);
    axi_read(32'h8, 8'd0, 3'd3, 2'b01, 1'b0);
    set_beats(3, 64'hC0);
    axi_write(32'h1FF0, 8'd3, 3'd3, 2'b01);
    axi_read(32'h1FF0, 8'd3, 3'd3, 2'b01, 1'b0);
    axi_read(32'h0, 8'd1, 3'd3, 2'b01, 1'b0);

    set_beats(3, 64'hDEAD0000);
    axi_write(32'h40, 8'd3, 3'd3, 2'b10);
    axi_write(32'h40, 8'd3, 3'd2, 2'b01);
    axi_read(32'h40, 8'd3, 3'd3, 2'b10, 1'b0);
    axi_read(32'h40, 8'd3, 3'd2, 2'b01, 1'b0);
    axi_read(32'h40, 8'd0, 3'd3, 2'b01, 1'b0);

    set_beats(3, 64'h5500);
    for (int k = 0; k < 4; k++) wlst[k] = (k == 1);
    axi_write(32'h200, 8'd3, 3'd3, 2'b01);
    axi_read(32'h200, 8'd3, 3'd3, 2'b01, 1'b0);
    axi_read(32'h1000, 8'd3, 3'd3, 2'b01, 1'b1);

    rready  = 1'b0;
    awaddr  = 32'h1800;
    awlen   = 8'd7;
    awsize  = 3'd3;
    awburst = 2'b01;
    awvalid = 1'b1;
    araddr  = 32'h1000;
    arlen   = 8'd7;
    arsize  = 3'd3;
    arburst = 2'b01;
    arvalid = 1'b1;
    step();
    chk("dual_aw_taken", {63'd0, awready}, 64'd0);
    chk("dual_ar_taken", {63'd0, arready}, 64'd0);
    awvalid = 1'b0;
    arvalid = 1'b0;
    wdata  = 64'h77;
    wstrb  = 8'hFF;
    wlast  = 1'b0;
    wvalid = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_ctl",
        {54'd0, awready, wready, bvalid, bresp,
         arready, rvalid, rresp, rlast}, 64'd0);
    chk("rst_mid_rdata", rdata, 64'd0);
    rst    = 1'b0;
    wvalid = 1'b0;
    rready = 1'b1;
    bready = 1'b1;
    step();
    chk("awready_rel", {63'd0, awready}, 64'd1);
    chk("arready_rel", {63'd0, arready}, 64'd1);
    repeat (10) begin
      step();
      chk("no_stray", {62'd0, bvalid, rvalid}, 64'd0);
    end

    chk("b_q_empty", 64'(exp_b.size()), 64'd0);
    chk("r_q_empty", 64'(exp_r.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
